// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } if_entry_t;

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fifo2.sv
// Two-entry fetch buffer between the IM response and ID; clear has priority.
module if_fifo2
  import if_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      push,
  input  if_entry_t push_data,
  input  logic      pop,
  output logic [1:0] count,
  output if_entry_t head
);

  if_entry_t  mem_r [2];
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       do_pop_s;
  logic       do_push_s;
  logic       wr_ptr_s;

  // Qualify push/pop against occupancy and locate the write slot
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
    wr_ptr_s  = rd_ptr_r ^ count_r[0];
  end

  // Storage, read pointer and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (clear) begin
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) mem_r[wr_ptr_s] <= push_data;
      if (do_pop_s) rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC sequencing, IM SRAM requests and a 2-deep buffer to ID.
// Optional macro IF_MISALIGN_CHK_EN enables misaligned-redirect fault reporting.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 14
) (
  input  logic             clk,
  input  logic             rst,
  output logic             im_cs,
  output logic             im_oe,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_do,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  input  logic             id_ready,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic             if_misalign
`endif
);

  if_state_e   state_r, state_nx;
  logic [31:0] pc_r;
  logic        infl_r;
  logic [31:0] infl_pc_r;
  logic        infl_mis_r;
  logic        mis_pend_r;
  logic        halt_r;

  logic        req_s;
  logic        fetch_ok_s;
  logic        room_s;
  logic        pop_s;
  logic        push_s;
  logic [31:0] tgt_s;
  logic        tgt_mis_s;
  logic [1:0]  count_s;
  if_entry_t   head_s;
  if_entry_t   push_entry_s;

`ifdef IF_MISALIGN_CHK_EN
  assign tgt_s     = redirect_pc;
  assign tgt_mis_s = |redirect_pc[1:0];
`else
  logic unused_s;
  assign tgt_s     = {redirect_pc[31:2], 2'b00};
  assign tgt_mis_s = 1'b0;
  assign unused_s  = ^{redirect_pc[1:0], head_s.misalign};
`endif

  // Room check counts the in-flight slot and frees the one ID takes this cycle
  always_comb begin
    pop_s      = if_valid && id_ready;
    room_s     = (({1'b0, count_s} + {2'b00, infl_r}) - {2'b00, pop_s}) < 3'd2;
    fetch_ok_s = !redirect_valid && room_s && !halt_r;
    push_s     = infl_r && !redirect_valid;
    push_entry_s.pc       = infl_pc_r;
    push_entry_s.inst     = infl_mis_r ? NOP : im_do;
    push_entry_s.misalign = infl_mis_r;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RST;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and fetch request; BOOT is left after one cycle and never re-entered
  always_comb begin
    state_nx = state_r;
    req_s    = 1'b0;
    case (state_r)
      ST_RST: begin
        state_nx = ST_BOOT;
        req_s    = 1'b0;
      end
      ST_BOOT: begin
        state_nx = ST_RUN;
        req_s    = fetch_ok_s;
      end
      ST_RUN: begin
        state_nx = ST_RUN;
        req_s    = fetch_ok_s;
      end
      default: begin
        state_nx = ST_RUN;
        req_s    = 1'b0;
      end
    endcase
  end

  // PC and in-flight tracking; a pending misaligned target takes a request slot
  // without touching the SRAM so its fault entry lands with normal latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r       <= RESET_PC;
      infl_r     <= 1'b0;
      infl_pc_r  <= 32'h0000_0000;
      infl_mis_r <= 1'b0;
      mis_pend_r <= 1'b0;
      halt_r     <= 1'b0;
    end else if (redirect_valid) begin
      pc_r       <= tgt_s;
      infl_r     <= 1'b0;
      infl_mis_r <= 1'b0;
      mis_pend_r <= tgt_mis_s;
      halt_r     <= 1'b0;
    end else if (req_s) begin
      pc_r       <= pc_inc(pc_r);
      infl_r     <= 1'b1;
      infl_pc_r  <= pc_r;
      infl_mis_r <= mis_pend_r;
      mis_pend_r <= 1'b0;
      halt_r     <= mis_pend_r;
    end else begin
      infl_r     <= 1'b0;
      infl_mis_r <= 1'b0;
    end
  end

  if_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .count     (count_s),
    .head      (head_s)
  );

  assign im_cs    = req_s && !mis_pend_r;
  assign im_addr  = im_cs ? pc_r[IM_AW+1:2] : '0;
  assign im_oe    = infl_r && !infl_mis_r;
  assign if_valid = (count_s != 2'd0);
  assign if_pc    = head_s.pc;
  assign if_inst  = head_s.inst;
`ifdef IF_MISALIGN_CHK_EN
  assign if_misalign = head_s.misalign;
`endif

endmodule
